// File: rtl/serial_cmp_ctrl.sv
// -----------------------------------------------------------------------------
// serial_cmp_ctrl
//
// Multi-cycle magnitude comparator for wide operands. A single 4-bit slice is
// reused one nibble per cycle, MSB first, stopping at the first nibble that
// differs. If every nibble matches, the result is taken from the cascade
// inputs, so the block is a drop-in for a cascaded WIDTH-bit comparator.
// WIDTH must be a multiple of 4 and at least 4.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start                request a compare; accepted in IDLE or DONE only
//   a, b                 operands, latched on the accepting edge
//   iagtb/iaeqb/ialtb    lower-order cascade inputs, latched with operands
//   busy                 high while nibbles are being compared
//   done                 one-cycle pulse when a new result is available
//   oagtb/oaeqb/oaltb    result flags, held until the next decision
//   ncmp                 nibbles examined by the last compare (1..NIB)
// -----------------------------------------------------------------------------
module serial_cmp_ctrl #(
  parameter  int WIDTH = 12,
  localparam int NIB   = WIDTH / 4,
  localparam int CW    = $clog2(NIB + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             iagtb,
  input  logic             iaeqb,
  input  logic             ialtb,
  output logic             busy,
  output logic             done,
  output logic             oagtb,
  output logic             oaeqb,
  output logic             oaltb,
  output logic [CW-1:0]    ncmp
);

  // Nibble index width; at least one bit so a single-nibble build still works.
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       cas_q;     // {gt, eq, lt} cascade copy
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    cnt_q;     // nibbles examined so far in this compare
  logic             busy_q, done_q;
  logic             gt_q, eq_q, lt_q;
  logic [CW-1:0]    ncmp_q;

  // The single shared 4-bit comparator slice.
  logic [3:0] nib_a, nib_b;
  logic       nib_gt, nib_lt, nib_eq;
  logic [CW-1:0] cnt_d;

  assign nib_a  = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b  = b_q[{idx_q, 2'b00} +: 4];
  assign nib_gt = (nib_a > nib_b);
  assign nib_lt = (nib_a < nib_b);
  assign nib_eq = (nib_a == nib_b);
  assign cnt_d  = cnt_q + CW'(1);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cas_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      ncmp_q  <= '0;
    end else begin
      case (state_q)
        // IDLE and DONE accept a request identically, giving back-to-back
        // compares with no idle gap after DONE.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            cas_q   <= {iagtb, iaeqb, ialtb};
            idx_q   <= IW'(NIB - 1);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        RUN: begin
          cnt_q <= cnt_d;
          if (!nib_eq || idx_q == '0) begin
            // Decision edge: results and count change only here.
            if (!nib_eq) begin
              gt_q <= nib_gt;
              eq_q <= 1'b0;
              lt_q <= nib_lt;
            end else begin
              gt_q <= cas_q[2];
              eq_q <= cas_q[1];
              lt_q <= cas_q[0];
            end
            ncmp_q  <= cnt_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign oagtb = gt_q;
  assign oaeqb = eq_q;
  assign oaltb = lt_q;
  assign ncmp  = ncmp_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_cmp_ctrl
//
// Self-checking bench for serial_cmp_ctrl (WIDTH=12): reset, directed
// compares, handshake corner cases and a seeded random sweep against a
// behavioural reference comparator.
// -----------------------------------------------------------------------------
module tb_serial_cmp_ctrl;

  localparam int WIDTH = 12;
  localparam int NIB   = WIDTH / 4;
  localparam int CW    = $clog2(NIB + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             iagtb, iaeqb, ialtb;
  logic             busy, done, oagtb, oaeqb, oaltb;
  logic [CW-1:0]    ncmp;

  int n_checks = 0;
  int n_errors = 0;

  serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .iagtb (iagtb),
    .iaeqb (iaeqb),
    .ialtb (ialtb),
    .busy  (busy),
    .done  (done),
    .oagtb (oagtb),
    .oaeqb (oaeqb),
    .oaltb (oaltb),
    .ncmp  (ncmp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive a request at a falling edge and hold start across one rising edge.
  task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic [2:0] tc);
    @(negedge clk);
    a = ta; b = tb; {iagtb, iaeqb, ialtb} = tc;
    start = 1'b1;
    @(posedge clk);
  endtask

  // After the accepting edge, count busy cycles until done is seen.
  task automatic wait_done(input string tag, output int k);
    bit seen = 0;
    k = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) k++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_result(input string tag, input int k,
                              input logic [2:0] exp_flags, input int exp_n);
    check({tag, "_flags"}, {29'd0, oagtb, oaeqb, oaltb}, {29'd0, exp_flags});
    check({tag, "_ncmp"}, 32'(ncmp), 32'(exp_n));
    check({tag, "_busy_cycles"}, 32'(k), 32'(exp_n));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
  endtask

  int               k;
  bit               saw_done;
  logic [WIDTH-1:0] ra, rb;
  logic [2:0]       rc, exp_f;
  int               exp_n;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    {iagtb, iaeqb, ialtb} = 3'b000;
    repeat (2) @(negedge clk);
    check("reset_outputs", {25'd0, busy, done, oagtb, oaeqb, oaltb, ncmp},
          32'd0);
    rst_n = 1'b1;

    // MSB nibble decides: A > 5.
    issue(12'hA00, 12'h500, 3'b010);
    wait_done("msb", k);
    check_result("msb", k, 3'b100, 1);

    // Done is a single-cycle pulse; results hold afterwards.
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'd0);
    check("hold_after_done", {29'd0, oagtb, oaeqb, oaltb}, 32'b100);

    // LSB nibble decides: 3 < 4.
    issue(12'h123, 12'h124, 3'b010);
    wait_done("lsb", k);
    check_result("lsb", k, 3'b001, 3);

    // All nibbles equal: cascade passes through.
    issue(12'h7E5, 12'h7E5, 3'b010);
    wait_done("eq_cas_eq", k);
    check_result("eq_cas_eq", k, 3'b010, 3);
    issue(12'h7E5, 12'h7E5, 3'b100);
    wait_done("eq_cas_gt", k);
    check_result("eq_cas_gt", k, 3'b100, 3);

    // start pulsed during RUN with other operands must be ignored.
    issue(12'h123, 12'h124, 3'b010);
    @(negedge clk);
    check("run_busy", 32'(busy), 32'd1);
    a = 12'hFFF; b = 12'h000; {iagtb, iaeqb, ialtb} = 3'b100;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", k);
    check("ignore_flags", {29'd0, oagtb, oaeqb, oaltb}, 32'b001);
    check("ignore_ncmp", 32'(ncmp), 32'd3);

    // Back-to-back: start held in the DONE cycle launches the next compare.
    issue(12'h7E5, 12'h7E4, 3'b010);
    wait_done("b2b_first", k);
    check_result("b2b_first", k, 3'b100, 3);
    a = 12'h300; b = 12'h500; {iagtb, iaeqb, ialtb} = 3'b010;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_gap_busy", 32'(busy), 32'd1);
    check("b2b_no_gap_done", 32'(done), 32'd0);
    @(negedge clk);
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_second_flags", {29'd0, oagtb, oaeqb, oaltb}, 32'b001);
    check("b2b_second_ncmp", 32'(ncmp), 32'd1);

    // Reset in the middle of RUN: outputs clear at once, no done afterwards.
    issue(12'h123, 12'h124, 3'b010);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs",
          {25'd0, busy, done, oagtb, oaeqb, oaltb, ncmp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("midrun_reset_no_done", 32'(saw_done), 32'd0);

    // Random sweep; b is often derived from a so that leading nibbles match.
    for (int i = 0; i < 1000; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = WIDTH'($urandom);
        1:       rb = {ra[11:4], 4'(WIDTH'($urandom))};
        2:       rb = {ra[11:8], 8'(WIDTH'($urandom))};
        default: rb = ra;
      endcase
      case ($urandom_range(0, 2))
        0:       rc = 3'b100;
        1:       rc = 3'b010;
        default: rc = 3'b001;
      endcase
      exp_f = {(ra > rb) || (ra == rb && rc[2]),
               (ra == rb) && rc[1],
               (ra < rb) || (ra == rb && rc[0])};
      exp_n = 1;
      for (int n = NIB - 1; n > 0; n--) begin
        if (ra[4*n +: 4] != rb[4*n +: 4]) break;
        exp_n++;
      end
      issue(ra, rb, rc);
      wait_done("rand", k);
      check("rand_flags", {29'd0, oagtb, oaeqb, oaltb}, {29'd0, exp_f});
      check("rand_ncmp", 32'(ncmp), 32'(exp_n));
      check("rand_busy_cycles", 32'(k), 32'(exp_n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
